// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Burst/packet beat counter width; saturates rather than wrapping.
  localparam int BEAT_CNT_W = 16;

  // Width of a producer index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotating-priority encoder: first set request strictly after last_gnt,
// wrapping modulo NUM_REQ. last_gnt itself has the lowest priority.
module fifo_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_gnt,
  output logic [ID_W-1:0]    pick,
  output logic               any
);

  // Scan from farthest to nearest so the nearest valid request wins.
  always_comb begin
    int idx;
    logic [ID_W-1:0] idx_c;
    pick  = last_gnt;
    any   = 1'b0;
    idx   = 0;
    idx_c = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx   = (int'(last_gnt) + k) % NUM_REQ;
      idx_c = ID_W'(idx);
      if (req[idx_c]) begin
        pick = idx_c;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// Burst-limited grants, fill-level throttle, registered write stage.
// Optional build macro FIFO_ARB_PKT_LOCK_EN: hold the grant until a beat
// flagged req_last is accepted (burst limit and idle release disabled).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 10,
  parameter int HIGH_WATER = 1020,
  parameter int MAX_BURST  = 8,
  localparam int ID_W      = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wrreq,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_full,
  input  logic [ADDR_BITS-1:0]          fifo_usedw,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  arb_state_e                         state_q, state_d;
  logic [ID_W-1:0]                    last_gnt_q;
  logic [ID_W-1:0]                    pick;
  logic                               any_req;
  logic [BEAT_CNT_W-1:0]              beat_cnt_q;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;
  logic                               can_wr;
  logic                               accept;
  logic                               release_gnt;
  logic                               new_grant;

  assign data_a = req_data;

  // Throttle leaves one slot of headroom for the write already in the register.
  assign can_wr    = en & ~fifo_full & (int'(fifo_usedw) < HIGH_WATER);
  assign accept    = (state_q == ST_BUSY) & req_valid[grant_id] & can_wr;
  assign new_grant = (state_q == ST_IDLE) & (state_d == ST_BUSY);

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req      (req_valid),
    .last_gnt (last_gnt_q),
    .pick     (pick),
    .any      (any_req)
  );

`ifdef FIFO_ARB_PKT_LOCK_EN
  // Grant ends only on the accepted last beat of a packet.
  assign release_gnt = accept & req_last[grant_id];
`else
  // Grant ends on the final beat of a burst, or when the owner goes idle
  // (idle release is masked while disabled so a paused system keeps its grant).
  assign release_gnt = (accept & (beat_cnt_q == BEAT_CNT_W'(MAX_BURST - 1)))
                     | (en & ~req_valid[grant_id]);
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: grant from IDLE when enabled, release from BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en & any_req) state_d = ST_BUSY;
      ST_BUSY: if (release_gnt)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: only the granted producer may see ready, and only when writable.
  always_comb begin
    req_ready = '0;
    busy      = (state_q == ST_BUSY);
    if ((state_q == ST_BUSY) && can_wr) req_ready[grant_id] = 1'b1;
  end

  // Grant bookkeeping: latch the pick, count accepted beats (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id   <= '0;
      last_gnt_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else if (new_grant) begin
      grant_id   <= pick;
      last_gnt_q <= pick;
      beat_cnt_q <= '0;
    end else if (accept && (beat_cnt_q != '1)) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  // Registered write stage; data holds between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
    end else begin
      fifo_wrreq <= accept;
      if (accept) fifo_data <= data_a[grant_id];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle model plus directed literal checks.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AB = 10;
  localparam int HW = 1020;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_wrreq;
  logic [DW-1:0]   fifo_data;
  logic            fifo_full  = 1'b0;
  logic [AB-1:0]   fifo_usedw = '0;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_BITS(AB), .HIGH_WATER(HW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .fifo_full(fifo_full), .fifo_usedw(fifo_usedw),
    .grant_id(grant_id), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Log of fifo writes as seen by the fifo.
  logic [15:0] wdat[$];
  int          wcyc[$];
  int          rcyc[$];
  always @(negedge clk) begin
    if (fifo_wrreq === 1'b1) begin
      wdat.push_back(fifo_data);
      wcyc.push_back(cyc);
    end
  end

  // Behavioural model: who owns the port, how many beats this grant, what the fifo sees.
  bit          m_init  = 0;
  int          m_owner = -1;
  int          m_last  = N - 1;
  int          m_gid   = 0;
  int          m_beats = 0;
  bit          m_wr    = 0;
  logic [15:0] m_data  = '0;

  always @(negedge clk) begin
    bit           can, acc, rel;
    logic [N-1:0] exp_rdy;
    can = en && !fifo_full && (int'(fifo_usedw) < HW);
    if (m_init) begin
      chk("busy", busy, m_owner >= 0);
      chk("grant_id", grant_id, m_gid);
      chk("fifo_wrreq", fifo_wrreq, m_wr);
      if (m_wr) chk("fifo_data", fifo_data, m_data);
      exp_rdy = '0;
      if (m_owner >= 0 && can) exp_rdy[m_owner] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
    end
    if (rst) begin
      m_init = 1; m_owner = -1; m_last = N - 1; m_gid = 0; m_beats = 0; m_wr = 0; m_data = '0;
    end else if (m_init) begin
      acc  = (m_owner >= 0) && req_valid[m_owner] && can;
      m_wr = acc;
      if (acc) m_data = req_data[m_owner*DW +: DW];
      if (m_owner < 0) begin
        if (en && (req_valid != '0)) begin
          for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) begin
              m_owner = (m_last + k) % N;
              break;
            end
          end
          m_gid = m_owner; m_last = m_owner; m_beats = 0;
        end
      end else begin
        if (acc) m_beats++;
`ifdef FIFO_ARB_PKT_LOCK_EN
        rel = acc && req_last[m_owner];
`else
        rel = (acc && m_beats == MB) || (en && !req_valid[m_owner]);
`endif
        if (rel) m_owner = -1;
      end
    end
  end

  // Directed producers: rem beats left, cnt beats sent, data = base + cnt.
  int          rem [N];
  int          cnt [N];
  logic [15:0] base[N];
  logic [AB-1:0] tb_usedw;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = (rem[i] != 0);
      req_last[i]           = (rem[i] == 1);
      req_data[i*DW +: DW]  = base[i] + 16'(cnt[i]);
    end
    fifo_usedw = tb_usedw;
  endtask

  task automatic step();
    logic [N-1:0] fire;
    @(negedge clk);
    fire = req_valid & req_ready & {N{~rst}};
    if (fire[2]) rcyc.push_back(cyc);
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) if (fire[i]) begin
      cnt[i]++;
      if (rem[i] > 0) rem[i]--;
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; cnt[i] = 0; base[i] = 16'(i * 256);
    end
    tb_usedw = '0; fifo_full = 1'b0; en = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wdat.delete(); wcyc.delete(); rcyc.delete();
  endtask

  task automatic wait_writes(input int n, input string name);
    int g;
    g = 0;
    while (wdat.size() < n && g < 400) begin step(); g++; end
    chk(name, wdat.size() >= n, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_ready", req_ready, 0);

`ifndef FIFO_ARB_PKT_LOCK_EN
    // All producers always valid: 0,1,2,3,0 with 8 beats each, one bubble between.
    for (int i = 0; i < N; i++) rem[i] = 100000;
    drive();
    wait_writes(33, "t1_timeout");
    if (wdat.size() >= 33) begin
      for (int k = 0; k < 33; k++) begin
        chk("t1_prod", wdat[k][15:8], (k / 8) % 4);
        chk("t1_beat", wdat[k][7:0], (k < 32) ? k % 8 : 8);
      end
      for (int k = 0; k < 32; k++) chk("t1_gap", wcyc[k+1] - wcyc[k], (k % 8 == 7) ? 2 : 1);
    end
`else
    // Packet lock: producer 0 holds the port for its whole 12-beat packet.
    rem[0] = 12; rem[1] = 3;
    drive();
    wait_writes(15, "t5_timeout");
    if (wdat.size() >= 15) begin
      for (int k = 0; k < 12; k++) chk("t5_p0", wdat[k], k);
      for (int k = 0; k < 11; k++) chk("t5_gap", wcyc[k+1] - wcyc[k], 1);
      chk("t5_next", wdat[12][15:8], 1);
      chk("t5_bubble", wcyc[12] - wcyc[11], 2);
    end
`endif

    // Only producer 2, beats A1..A3, each written one cycle after its ready.
    do_reset();
    rem[2] = 3; base[2] = 16'h00A1;
    drive();
    repeat (12) step();
    chk("t2_count", wdat.size(), 3);
    chk("t2_rdy_count", rcyc.size(), 3);
    if (wdat.size() == 3 && rcyc.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("t2_data", wdat[k], 16'h00A1 + 16'(k));
        chk("t2_lat", wcyc[k], rcyc[k] + 1);
      end
    end

    // Fill-level throttle holds the grant and stops transfers.
    do_reset();
    rem[0] = 100000;
    drive();
    wait_writes(3, "t3_timeout");
    tb_usedw = 10'd1020;
    step(); #1;
    chk("t3_ready_hw", req_ready, 0);
    chk("t3_busy_hw", busy, 1);
    step();
    chk("t3_wrreq_hw", fifo_wrreq, 0);
    chk("t3_grant_hw", grant_id, 0);
    chk("t3_busy_hold", busy, 1);
    tb_usedw = 10'd1019;
    step(); #1;
    chk("t3_ready_resume", req_ready, 4'b0001);

    // Producer 1 stops after 2 beats; producer 3 takes over.
    do_reset();
    rem[1] = 2; rem[3] = 5;
    drive();
    repeat (25) step();
    chk("t4_count", wdat.size(), 7);
    if (wdat.size() == 7) begin
      for (int k = 0; k < 7; k++) chk("t4_prod", wdat[k][15:8], (k < 2) ? 1 : 3);
    end
    chk("t4_grant", grant_id, 3);
    chk("t4_idle", busy, 0);

    // Reset on an accepting cycle discards the beat and restores priority to 0.
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 100000;
    drive();
    wait_writes(3, "t6_timeout");
    #1;
    chk("t6_pre_ready", req_ready, 4'b0001);
    rst = 1'b1;
    step();
    chk("t6_wrreq", fifo_wrreq, 0);
    chk("t6_busy", busy, 0);
    chk("t6_grant", grant_id, 0);
    rst = 1'b0;
    step();
    chk("t6_regrant_busy", busy, 1);
    chk("t6_regrant_id", grant_id, 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #2;
      req_valid = N'($urandom_range(0, 15));
      req_data  = {$urandom, $urandom};
      req_last  = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      en        = ($urandom_range(0, 9) != 0);
      fifo_full = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0:       fifo_usedw = 10'd1018;
        1:       fifo_usedw = 10'd1019;
        2:       fifo_usedw = 10'd1020;
        3:       fifo_usedw = 10'd1021;
        default: fifo_usedw = AB'($urandom);
      endcase
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
